aes128_write_to_fifo: RTL and testbench

Register-mapped loader and result port for AES-128 encryption on the shell's OCL-style register bus. Software writes a 128-bit key and then a 128-bit plaintext one byte per write, each tagged with its byte slot. The block feeds them to the codebase AES-128 core (`aes_128`: `clk`, `state[127:0]`, `key[127:0]`, `out[127:0]`) and exposes the ciphertext through a 32-bit read channel.

---
 rtl/aes128_write_to_fifo.sv | 198 +++++++++++++++++++
 tb/tb_aes128_write_to_fifo.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/aes128_write_to_fifo.sv
// aes128_write_to_fifo: byte-wise AES-128 key/plaintext loader on the OCL-style register bus,
// plus the aes_128 core it drives (round-pipelined, result valid well inside AES_LATENCY).

module aes_128 (
  input  logic         clk,
  input  logic [127:0] state,
  input  logic [127:0] key,
  output logic [127:0] out
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [79:0] RCON = 80'h01020408102040801b36;

  // Table entry for byte b sits at the top of SBOX for b=0
  function automatic logic [7:0] sub(input logic [7:0] b);
    logic [10:0] idx;
    idx = {~b, 3'b000};
    return SBOX[idx +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {sub(k[23:16]) ^ rc, sub(k[15:8]), sub(k[7:0]), sub(k[31:24])};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // SubBytes, ShiftRows, MixColumns (skipped in the last round), AddRoundKey
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) b[i] = sub(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) t[4*c+r] = b[4*((c+r)%4)+r];
    end
    for (int c = 0; c < 4; c++) begin
      a0 = t[4*c];
      a1 = t[4*c+1];
      a2 = t[4*c+2];
      a3 = t[4*c+3];
      if (last) begin
        res[127-32*c -: 32] = {a0, a1, a2, a3};
      end else begin
        res[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                               a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                               a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                               xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
      end
    end
    return res ^ rk;
  endfunction

  logic [127:0] st_q [11];
  logic [127:0] rk_q [10];

  // One pipeline stage per round; round keys travel alongside the state
  always_ff @(posedge clk) begin
    st_q[0] <= state ^ key;
    rk_q[0] <= key;
    for (int i = 0; i < 10; i++) begin
      st_q[i+1] <= aes_round(st_q[i], next_key(rk_q[i], RCON[79-8*i -: 8]), i == 9);
      if (i < 9) rk_q[i+1] <= next_key(rk_q[i], RCON[79-8*i -: 8]);
    end
  end

  assign out = st_q[10];

endmodule

module aes128_write_to_fifo #(
  parameter logic [31:0] REG_ADDR    = 32'h0000_0510,
  parameter int unsigned AES_LATENCY = 21
) (
  input  logic        clk_main_a0,
  input  logic        rst_main_n_sync,
  input  logic [31:0] wr_addr,
  input  logic        wready,
  input  logic [31:0] wdata,
  input  logic        rready,
  input  logic        arvalid_q,
  input  logic [31:0] araddr_q,
  input  logic [15:0] vled_q,
  output logic [1:0]  rresp,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic [31:0] hello_world_q
);

  localparam int unsigned LatW = $clog2(AES_LATENCY + 1);

  logic             wready_q, busy_q, done_q;
  logic [4:0]       cnt_q, cnt_eff;
  logic [LatW-1:0]  lat_q;
  logic [127:0]     key_q, pt_q, ct_q, ct_core;
  logic             accept;
  logic [3:0]       slot;
  logic [31:0]      status, offset;
  logic             unused_wdata;

  assign accept       = wready & ~wready_q & (wr_addr == REG_ADDR);
  // Tag t lands in byte t-1 counted from the LSB; tag 0 wraps to the MSB byte
  assign slot         = wdata[31:28] - 4'd1;
  // A write after completion restarts the load at the first key byte
  assign cnt_eff      = done_q ? 5'd0 : cnt_q;
  assign status       = {vled_q, 10'b0, done_q, cnt_q};
  assign offset       = araddr_q - REG_ADDR;
  assign unused_wdata = ^wdata[27:8];

  aes_128 u_aes (
    .clk   (clk_main_a0),
    .state (pt_q),
    .key   (key_q),
    .out   (ct_core)
  );

  // Byte loading, encryption start and fixed-latency result capture
  always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
    if (!rst_main_n_sync) begin
      wready_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= 5'd0;
      lat_q    <= '0;
      key_q    <= '0;
      pt_q     <= '0;
      ct_q     <= '0;
    end else begin
      wready_q <= wready;
      if (busy_q) begin
        if (lat_q == LatW'(AES_LATENCY)) begin
          ct_q   <= ct_core;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          lat_q <= lat_q + LatW'(1);
        end
      end else if (accept) begin
        if (cnt_eff[4]) pt_q[{slot, 3'b000} +: 8] <= wdata[7:0];
        else            key_q[{slot, 3'b000} +: 8] <= wdata[7:0];
        cnt_q  <= cnt_eff + 5'd1;
        done_q <= 1'b0;
        if (cnt_eff == 5'd31) begin
          busy_q <= 1'b1;
          lat_q  <= '0;
        end
      end
    end
  end

  // Registered read channel and status word
  always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
    if (!rst_main_n_sync) begin
      rvalid        <= 1'b0;
      rresp         <= 2'b00;
      rdata         <= '0;
      hello_world_q <= '0;
    end else begin
      hello_world_q <= status;
      if (!rvalid && arvalid_q) begin
        rvalid <= 1'b1;
        rresp  <= 2'b00;
        case (offset)
          32'h0:   rdata <= done_q ? ct_q[127:96] : 32'h0;
          32'h4:   rdata <= done_q ? ct_q[95:64]  : 32'h0;
          32'h8:   rdata <= done_q ? ct_q[63:32]  : 32'h0;
          32'hc:   rdata <= done_q ? ct_q[31:0]   : 32'h0;
          32'h10:  rdata <= status;
          default: begin
            rdata <= 32'h0;
            rresp <= 2'b10;
          end
        endcase
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes128_write_to_fifo.sv
// Directed bench for aes128_write_to_fifo using the FIPS-197 AES-128 example vector.

module tb_aes128_write_to_fifo;

  localparam logic [31:0]  BASE = 32'h0000_0510;
  localparam int unsigned  LAT  = 21;
  localparam logic [127:0] KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [15:0]  VLED = 16'ha5c3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] wr_addr = '0;
  logic        wready = 1'b0;
  logic [31:0] wdata = '0;
  logic        rready = 1'b0;
  logic        arvalid = 1'b0;
  logic [31:0] araddr = '0;
  logic [15:0] vled = VLED;
  logic [1:0]  rresp;
  logic        rvalid;
  logic [31:0] rdata;
  logic [31:0] hello;

  logic [31:0] ct_w [4] = '{32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a};

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  aes128_write_to_fifo dut (
    .clk_main_a0     (clk),
    .rst_main_n_sync (rst_n),
    .wr_addr         (wr_addr),
    .wready          (wready),
    .wdata           (wdata),
    .rready          (rready),
    .arvalid_q       (arvalid),
    .araddr_q        (araddr),
    .vled_q          (vled),
    .rresp           (rresp),
    .rvalid          (rvalid),
    .rdata           (rdata),
    .hello_world_q   (hello)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One write pulse followed by an idle cycle so the next pulse is a fresh edge
  task automatic put(input logic [31:0] addr, input logic [3:0] tag, input logic [7:0] d);
    @(negedge clk);
    wr_addr = addr;
    wdata   = {tag, 20'h5a5a5, d};
    wready  = 1'b1;
    @(negedge clk);
    wready  = 1'b0;
  endtask

  // Stream index i: 0..15 key, 16..31 plaintext, tags 0,15,14..1 (MSB first)
  task automatic put_idx(input int i);
    logic [127:0] v;
    int j;
    v = (i < 16) ? KEY : PT;
    j = i % 16;
    put(BASE, (j == 0) ? 4'd0 : 4'(16 - j), v[127-8*j -: 8]);
  endtask

  task automatic load(input int from, input int to);
    for (int i = from; i <= to; i++) put_idx(i);
  endtask

  // 32nd write (tag 1, plaintext LSB 0xff) with exact completion timing
  task automatic finish_load(input string tag);
    @(negedge clk);
    wr_addr = BASE;
    wdata   = {4'd1, 20'h0, 8'hff};
    wready  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wready = 1'b0;
    repeat (LAT) @(posedge clk);
    @(posedge clk);
    #1 chk({tag, "_done_early"}, {31'b0, hello[5]}, 32'd0);
    @(posedge clk);
    #1 chk({tag, "_done_rise"}, {31'b0, hello[5]}, 32'd1);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp_d, input logic [1:0] exp_r,
                    input int stall, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    araddr  = addr;
    arvalid = 1'b1;
    rready  = 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while (!rvalid && n < 8);
    arvalid = 1'b0;
    chk({tag, "_rvalid"}, {31'b0, rvalid}, 32'd1);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      chk({tag, "_stall_valid"}, {31'b0, rvalid}, 32'd1);
      chk({tag, "_stall_data"}, rdata, exp_d);
    end
    chk({tag, "_rdata"}, rdata, exp_d);
    chk({tag, "_rresp"}, {30'b0, rresp}, {30'b0, exp_r});
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    chk({tag, "_rvalid_drop"}, {31'b0, rvalid}, 32'd0);
  endtask

  task automatic rd_ct(input string tag);
    for (int k = 0; k < 4; k++) rd(BASE + 32'(4 * k), ct_w[k], 2'b00, 0, tag);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rvalid"}, {31'b0, rvalid}, 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_rresp"}, {30'b0, rresp}, 32'd0);
    chk({tag, "_status"}, hello, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #100;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Key load then status and early reads
    load(0, 15);
    @(negedge clk);
    chk("key_status", hello, {VLED, 10'b0, 1'b0, 5'd16});
    rd(BASE + 32'h10, {VLED, 10'b0, 1'b0, 5'd16}, 2'b00, 0, "status_read");
    rd(BASE, 32'h0, 2'b00, 0, "ct_before_done");

    // Plaintext load and result
    load(16, 30);
    finish_load("first");
    rd_ct("ct_first");

    // Unmapped address and held rready
    rd(32'h0000_0600, 32'h0, 2'b10, 4, "bad_addr");
    rd(BASE + 32'h4, ct_w[1], 2'b00, 3, "ct1_stall");

    // Level-held wready counts once; write to wrong address ignored; restart after done
    @(negedge clk);
    wr_addr = BASE;
    wdata   = {4'd0, 20'h0, 8'h00};
    wready  = 1'b1;
    repeat (3) @(negedge clk);
    wready = 1'b0;
    put(32'h0000_0500, 4'd1, 8'hcd);
    @(negedge clk);
    chk("hold_status", hello, {VLED, 10'b0, 1'b0, 5'd1});
    rd(BASE + 32'hc, 32'h0, 2'b00, 0, "ct_after_restart");
    load(1, 30);
    finish_load("second");
    rd_ct("ct_second");

    // Reset in the middle of encryption
    load(0, 30);
    put_idx(31);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_reset_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_reset_status", hello, {VLED, 10'b0, 1'b0, 5'd0});
    rd(BASE, 32'h0, 2'b00, 0, "ct_post_reset");
    load(0, 30);
    finish_load("third");
    rd_ct("ct_third");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
